sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port Avalon-MM arbiter that shares the single 64-bit DDR3 SDRAM port between a scanout read master (port 0, display) and a raster/fill master (port 1, e.g. framebuffer writer). It sits between the GPU masters and the HPS SDRAM Avalon slave. It grants one single-beat command at a time, holds the command stable under `waitrequest`, and routes returning `readdatavalid` beats to the issuing port through an in-order ID FIFO.

## Interface
- `ADDR_W`, 29: word address width (64-bit units).
- `DATA_W`, 64: data width; byteenable width is `DATA_W/8`.
- `MAX_PENDING`, 8: max outstanding reads (ID FIFO depth, power of 2).

Ports:
- `systemClock`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `mN_address`  in  ADDR_W  port N address (N = 0, 1).
- `mN_read`, `mN_write`  in  1  port N read / write request.
- `mN_writedata`  in  DATA_W  port N write data.
- `mN_byteenable`  in  DATA_W/8  port N byte enables.
- `mN_waitrequest`  out  1  port N stall; command accepted when request high and this low.
- `mN_readdata`  out  DATA_W  port N read data.
- `mN_readdatavalid`  out  1  port N read beat valid.
- `address`  out  ADDR_W  SDRAM address.
- `read`, `write`  out  1  SDRAM command.
- `writedata`  out  DATA_W  SDRAM write data.
- `byteenable`  out  DATA_W/8  SDRAM byte enables.
- `burstcount`  out  8  constant 8'h01.
- `waitrequest`  in  1  SDRAM stall.
- `readdata`  in  DATA_W  SDRAM read data.
- `readdatavalid`  in  1  SDRAM read beat valid.
- `err_orphan`  out  1  sticky: `readdatavalid` seen with ID FIFO empty.

## Operation
- States: IDLE, GRANT0, GRANT1 (2-bit register).
- IDLE: eligible port = request high (`read` or `write`) and, if read, ID FIFO not full. Both ports eligible -> port 0 wins (see Configuration). Next state GRANTn; none eligible -> stay IDLE.
- GRANTn: downstream `address/read/write/writedata/byteenable` = port n inputs combinationally; other port's fields ignored. `mn_waitrequest = waitrequest`; non-granted port `waitrequest = 1`.
- GRANTn with `waitrequest` low: command accepted; if read, push ID n into FIFO; next state IDLE.
- GRANTn with port n request dropped (protocol violation): return to IDLE, no command issued.
- Ports with `read` and `write` both high: treated as write.
- In IDLE, downstream `read = write = 0`; `m0/m1_waitrequest = 1`.
- Read return: `readdatavalid` -> pop FIFO head ID h; `mh_readdatavalid = 1`, `mh_readdata = readdata`. `mN_readdata` driven from `readdata` for both ports; only valid is gated.
- Push and pop in the same cycle allowed; occupancy unchanged. Count width clog2(MAX_PENDING)+1.
- `readdatavalid` with FIFO empty: beat dropped, `err_orphan` set until reset.
- Reset values: state IDLE, FIFO empty, `err_orphan = 0`, downstream `read = write = 0`, upstream `waitrequest = 1`, `readdatavalid = 0`.
- Reset mid-transaction: FIFO flushed; beats arriving afterward are orphans (flag set).

## Timing
- Arbitration latency: request in IDLE at cycle t -> downstream command visible at t+1.
- Zero-wait slave: one command every 2 cycles (grant, IDLE) per port pair.
- Read data path combinational: `readdatavalid` -> `mN_readdatavalid` same cycle.
- FIFO full: reads ineligible at IDLE; writes still granted.

## Configuration
- `SDRAM_ARB_ROUND_ROBIN_EN` defined: 1-bit `last_grant` register (reset 1, so port 0 wins first tie). On tie in IDLE, grant the port not equal to `last_grant`; update it on every accepted command.
- Undefined: fixed priority, port 0 always wins ties; no `last_grant` register.

## Test plan
- Port 0 read 29'h0700_0000, zero-wait slave -> `read` at t+1, FIFO count 1; `readdatavalid` with 64'hDEAD_BEEF_CAFE_BABE -> `m0_readdatavalid = 1`, `m0_readdata` matches; `m1_readdatavalid = 0`.
- Both ports request continuously (m0 read, m1 write 64'hFF0F_00FF_FF0F_FF00), fixed priority -> only m0 commands issue; with RR macro -> grants alternate 0,1,0,1.
- Slave holds `waitrequest` 5 cycles during GRANT1 write -> downstream address/data stable all 5 cycles; m1 accepted on cycle 6 only; m0 stalled throughout.
- 8 reads issued with no returns (MAX_PENDING=8) -> 9th read not granted, pending m1 write granted; one return then read granted.
- Push and pop same cycle at count 3 -> count stays 3; IDs returned in issue order.
- Reset pulse with 2 reads outstanding, then 2 `readdatavalid` beats -> no upstream valid, `err_orphan = 1`.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Avalon-MM single-beat command bus shared by the arbiter's upstream ports and
// its downstream SDRAM port. "master" drives commands, "slave" answers them.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port Avalon-MM arbiter in front of the 64-bit DDR3 SDRAM port.
// Port 0 is the scanout reader, port 1 the raster/fill master. One single-beat
// command is granted at a time and held stable under waitrequest; read beats
// are routed back to the issuing port through an in-order ID FIFO.
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN to break ties round-robin
// instead of always favouring port 0.
module sdram_arbiter #(
    parameter int ADDR_W      = 29,
    parameter int DATA_W      = 64,
    parameter int MAX_PENDING = 8
) (
    input  logic            systemClock,
    input  logic            reset,
    sdram_arbiter_if.slave  m0,
    sdram_arbiter_if.slave  m1,
    sdram_arbiter_if.master sdram,
    output logic [7:0]      burstcount,
    output logic            err_orphan
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    // One port's command after decoding read+write collisions into a write.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
    } cmd_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_orphan_q, err_orphan_d;
    logic             id_mem_q [MAX_PENDING];
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic             last_grant_q, last_grant_d;
`endif

    cmd_t cmd0, cmd1, cmd_sel;
    logic fifo_full, fifo_empty;
    logic elig0, elig1;
    logic in_grant, gnt_port, gnt_req;
    logic accept, push, pop, orphan;
    logic head_id;

    // Decode both upstream commands and the FIFO/handshake events of this cycle.
    always_comb begin
        cmd0.address    = m0.address;
        cmd0.rd         = m0.read & ~m0.write;
        cmd0.wr         = m0.write;
        cmd0.writedata  = m0.writedata;
        cmd0.byteenable = m0.byteenable;

        cmd1.address    = m1.address;
        cmd1.rd         = m1.read & ~m1.write;
        cmd1.wr         = m1.write;
        cmd1.writedata  = m1.writedata;
        cmd1.byteenable = m1.byteenable;

        fifo_full  = (count_q == CNT_W'(MAX_PENDING));
        fifo_empty = (count_q == '0);

        // A read may only start if its returning beat has a FIFO slot.
        elig0 = cmd0.wr | (cmd0.rd & ~fifo_full);
        elig1 = cmd1.wr | (cmd1.rd & ~fifo_full);

        in_grant = (state_q == GRANT0) || (state_q == GRANT1);
        gnt_port = (state_q == GRANT1);
        cmd_sel  = gnt_port ? cmd1 : cmd0;
        gnt_req  = cmd_sel.rd | cmd_sel.wr;

        accept = in_grant & gnt_req & ~sdram.waitrequest;
        push   = accept & cmd_sel.rd;
        pop    = sdram.readdatavalid & ~fifo_empty;
        orphan = sdram.readdatavalid & fifo_empty;

        head_id = id_mem_q[rd_ptr_q];
    end

    // Route the granted port's command downstream and its stall back upstream.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path through the case leaves it unassigned and infers a latch.
        sdram.address     = '0;
        sdram.read        = 1'b0;
        sdram.write       = 1'b0;
        sdram.writedata   = '0;
        sdram.byteenable  = '0;
        m0.waitrequest    = 1'b1;
        m1.waitrequest    = 1'b1;
        if (in_grant) begin
            sdram.address    = cmd_sel.address;
            sdram.read       = cmd_sel.rd;
            sdram.write      = cmd_sel.wr;
            sdram.writedata  = cmd_sel.writedata;
            sdram.byteenable = cmd_sel.byteenable;
            if (gnt_port) begin
                m1.waitrequest = sdram.waitrequest;
            end else begin
                m0.waitrequest = sdram.waitrequest;
            end
        end
    end

    // Steer each returning beat to the port whose ID sits at the FIFO head.
    always_comb begin
        m0.readdata      = sdram.readdata;
        m1.readdata      = sdram.readdata;
        m0.readdatavalid = pop & ~head_id;
        m1.readdatavalid = pop &  head_id;
    end

    // Arbitration, FIFO bookkeeping and orphan-beat detection.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        err_orphan_d = err_orphan_q | orphan;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        last_grant_d = accept ? gnt_port : last_grant_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (elig0 && elig1) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                    state_d = last_grant_q ? GRANT0 : GRANT1;
`else
                    state_d = GRANT0;
`endif
                end else if (elig0) begin
                    state_d = GRANT0;
                end else if (elig1) begin
                    state_d = GRANT1;
                end
            end
            // Leave on acceptance, or when the master abandons its request.
            GRANT0, GRANT1: begin
                if (!gnt_req || !sdram.waitrequest) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset also flushes the ID FIFO.
    always_ff @(posedge systemClock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_orphan_q <= err_orphan_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // ID storage: records which port issued each outstanding read.
    always_ff @(posedge systemClock) begin
        // NOTE: the ID array is not reset; entries are only read between a push
        // and its pop, and the reset pointers/count already mark it empty.
        if (push) begin
            id_mem_q[wr_ptr_q] <= gnt_port;
        end
    end

    assign burstcount = 8'h01;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter. A cycle-level behavioural model (queue of
// issuing port IDs, current grant, sticky orphan flag) predicts every output on
// each falling edge; directed scenarios add hand-computed literal checks.
// Build with SDRAM_ARB_ROUND_ROBIN_EN defined to exercise round-robin ties.
module tb_sdram_arbiter;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int MAXP   = 8;

    logic systemClock = 1'b0;
    logic reset;
    logic [7:0] burstcount;
    logic err_orphan;

    int checks   = 0;
    int failures = 0;

    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sd_bus ();

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
        .systemClock (systemClock),
        .reset       (reset),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .sdram       (sd_bus),
        .burstcount  (burstcount),
        .err_orphan  (err_orphan)
    );

    always #5 systemClock = ~systemClock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_gnt  = -1;    // -1: nobody granted, else granted port
    bit m_q[$];         // issuing port of each outstanding read, oldest first
    bit m_orphan = 0;
    bit m_last   = 1;

    always @(negedge systemClock) begin : model_cmp
        int   g, sz;
        logic r, w, erd, ewr, ew0, ew1, ev0, ev1, el0, el1;
        if (reset) begin
            m_gnt = -1;
            m_q.delete();
            m_orphan = 0;
            m_last = 1;
        end
        g = m_gnt;
        r = 0; w = 0; erd = 0; ewr = 0; ew0 = 1; ew1 = 1;
        if (g >= 0) begin
            r = (g == 1) ? m1_bus.read  : m0_bus.read;
            w = (g == 1) ? m1_bus.write : m0_bus.write;
            ewr = w;
            erd = r & ~w;
            if (g == 0) ew0 = sd_bus.waitrequest;
            else        ew1 = sd_bus.waitrequest;
            if (erd | ewr) begin
                check("mdl_address", sd_bus.address, (g == 1) ? m1_bus.address : m0_bus.address);
                check("mdl_byteenable", sd_bus.byteenable, (g == 1) ? m1_bus.byteenable : m0_bus.byteenable);
            end
            if (ewr) check("mdl_writedata", sd_bus.writedata, (g == 1) ? m1_bus.writedata : m0_bus.writedata);
        end
        check("mdl_read", sd_bus.read, erd);
        check("mdl_write", sd_bus.write, ewr);
        check("mdl_m0_wait", m0_bus.waitrequest, ew0);
        check("mdl_m1_wait", m1_bus.waitrequest, ew1);
        sz  = m_q.size();
        ev0 = sd_bus.readdatavalid && (sz > 0) && (m_q[0] == 1'b0);
        ev1 = sd_bus.readdatavalid && (sz > 0) && (m_q[0] == 1'b1);
        check("mdl_m0_rdv", m0_bus.readdatavalid, ev0);
        check("mdl_m1_rdv", m1_bus.readdatavalid, ev1);
        if (ev0) check("mdl_m0_rdata", m0_bus.readdata, sd_bus.readdata);
        if (ev1) check("mdl_m1_rdata", m1_bus.readdata, sd_bus.readdata);
        check("mdl_orphan", err_orphan, m_orphan);
        check("mdl_burstcount", burstcount, 8'h01);

        if (!reset) begin
            el0 = m0_bus.write | (m0_bus.read & (sz < MAXP));
            el1 = m1_bus.write | (m1_bus.read & (sz < MAXP));
            if (sd_bus.readdatavalid) begin
                if (sz > 0) void'(m_q.pop_front());
                else        m_orphan = 1;
            end
            if (g < 0) begin
                if (el0 && el1) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                    m_gnt = m_last ? 0 : 1;
`else
                    m_gnt = 0;
`endif
                end else if (el0) m_gnt = 0;
                else if (el1)     m_gnt = 1;
            end else if (!(r | w)) begin
                m_gnt = -1;
            end else if (!sd_bus.waitrequest) begin
                if (erd) m_q.push_back(bit'(g));
                m_last = bit'(g);
                m_gnt  = -1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge systemClock);
        #1;
    endtask

    task automatic neg();
        @(negedge systemClock);
    endtask

    task automatic issue_read(input int p);
        if (p == 1) m1_bus.read = 1'b1;
        else        m0_bus.read = 1'b1;
        step();
        step();
        m0_bus.read = 1'b0;
        m1_bus.read = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n_acc;
        logic [3:0] seq;
        reset = 1'b1;
        m0_bus.address = '0; m0_bus.read = 0; m0_bus.write = 0; m0_bus.writedata = '0; m0_bus.byteenable = 8'hFF;
        m1_bus.address = '0; m1_bus.read = 0; m1_bus.write = 0; m1_bus.writedata = '0; m1_bus.byteenable = 8'hFF;
        sd_bus.waitrequest = 1'b0; sd_bus.readdata = '0; sd_bus.readdatavalid = 1'b0;

        // Reset values
        neg();
        check("rst_m0_wait", m0_bus.waitrequest, 1);
        check("rst_m1_wait", m1_bus.waitrequest, 1);
        check("rst_read", sd_bus.read, 0);
        check("rst_write", sd_bus.write, 0);
        check("rst_orphan", err_orphan, 0);
        step();
        reset = 1'b0;
        step();

        // Single port-0 read, zero-wait slave, then its data beat
        m0_bus.address = 29'h0700_0000;
        m0_bus.read    = 1'b1;
        neg();
        check("t1_no_cmd_same_cycle", sd_bus.read, 0);
        step();
        neg();
        check("t1_read_next_cycle", sd_bus.read, 1);
        check("t1_address", sd_bus.address, 29'h0700_0000);
        check("t1_m0_accept", m0_bus.waitrequest, 0);
        step();
        m0_bus.read = 1'b0;
        sd_bus.readdatavalid = 1'b1;
        sd_bus.readdata      = 64'hDEAD_BEEF_CAFE_BABE;
        neg();
        check("t1_m0_rdv", m0_bus.readdatavalid, 1);
        check("t1_m0_rdata", m0_bus.readdata, 64'hDEAD_BEEF_CAFE_BABE);
        check("t1_m1_rdv", m1_bus.readdatavalid, 0);
        step();
        sd_bus.readdatavalid = 1'b0;

        // Both ports request continuously
        m0_bus.address   = 29'h0000_0100;
        m0_bus.read      = 1'b1;
        m1_bus.address   = 29'h0000_0200;
        m1_bus.writedata = 64'hFF0F_00FF_FF0F_FF00;
        m1_bus.write     = 1'b1;
        n_acc = 0;
        seq   = '0;
        for (int i = 0; i < 8; i++) begin
            neg();
            if ((sd_bus.read || sd_bus.write) && !sd_bus.waitrequest) begin
                n_acc++;
                seq = {seq[2:0], sd_bus.write};
            end
            step();
        end
        m0_bus.read  = 1'b0;
        m1_bus.write = 1'b0;
        check("t2_accepted", n_acc, 4);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        check("t2_grant_order", seq, 4'b1010);
`else
        check("t2_grant_order", seq, 4'b0000);
`endif
        sd_bus.readdatavalid = 1'b1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 2; i++) begin
`else
        for (int i = 0; i < 4; i++) begin
`endif
            sd_bus.readdata = 64'h1000 + 64'(i);
            neg();
            check("t2_drain_m0_rdv", m0_bus.readdatavalid, 1);
            step();
        end
        sd_bus.readdatavalid = 1'b0;

        // Slave stalls a port-1 write for 5 cycles; port 0 waits behind it
        sd_bus.waitrequest = 1'b1;
        m1_bus.address     = 29'h123_4567;
        m1_bus.writedata   = 64'h0123_4567_89AB_CDEF;
        m1_bus.byteenable  = 8'h0F;
        m1_bus.write       = 1'b1;
        step();
        m0_bus.address = 29'h0000_0300;
        m0_bus.read    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            neg();
            check("t3_write_held", sd_bus.write, 1);
            check("t3_addr_stable", sd_bus.address, 29'h123_4567);
            check("t3_data_stable", sd_bus.writedata, 64'h0123_4567_89AB_CDEF);
            check("t3_be_stable", sd_bus.byteenable, 8'h0F);
            check("t3_m1_stalled", m1_bus.waitrequest, 1);
            check("t3_m0_stalled", m0_bus.waitrequest, 1);
            step();
        end
        sd_bus.waitrequest = 1'b0;
        neg();
        check("t3_m1_accept", m1_bus.waitrequest, 0);
        check("t3_m0_still_stalled", m0_bus.waitrequest, 1);
        step();
        m1_bus.write      = 1'b0;
        m1_bus.byteenable = 8'hFF;
        step();
        neg();
        check("t3_m0_read_after", sd_bus.read, 1);
        step();
        m0_bus.read = 1'b0;
        sd_bus.readdatavalid = 1'b1;
        sd_bus.readdata      = 64'h0000_0000_0000_0300;
        neg();
        check("t3_m0_rdv", m0_bus.readdatavalid, 1);
        step();
        sd_bus.readdatavalid = 1'b0;

        // Fill the ID FIFO with 8 reads; the 9th waits, a write still goes
        m0_bus.address = 29'h0000_0400;
        m0_bus.read    = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            neg();
            if (sd_bus.read && !sd_bus.waitrequest) n_acc++;
            step();
        end
        check("t4_reads_issued", n_acc, 8);
        m1_bus.address   = 29'h0000_0500;
        m1_bus.writedata = 64'h5555_AAAA_5555_AAAA;
        m1_bus.write     = 1'b1;
        neg();
        check("t4_full_no_read", sd_bus.read, 0);
        check("t4_full_m0_wait", m0_bus.waitrequest, 1);
        step();
        neg();
        check("t4_write_granted", sd_bus.write, 1);
        check("t4_write_addr", sd_bus.address, 29'h0000_0500);
        step();
        m1_bus.write = 1'b0;
        neg();
        check("t4_still_blocked", sd_bus.read, 0);
        step();
        sd_bus.readdatavalid = 1'b1;
        sd_bus.readdata      = 64'h0000_0000_0000_0400;
        neg();
        check("t4_return_m0", m0_bus.readdatavalid, 1);
        step();
        sd_bus.readdatavalid = 1'b0;
        step();
        neg();
        check("t4_read_after_return", sd_bus.read, 1);
        step();
        m0_bus.read = 1'b0;
        sd_bus.readdatavalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sd_bus.readdata = 64'h2000 + 64'(i);
            neg();
            check("t4_drain_m0_rdv", m0_bus.readdatavalid, 1);
            step();
        end
        sd_bus.readdatavalid = 1'b0;

        // Push and pop in the same cycle at occupancy 3, then in-order returns
        issue_read(0);
        issue_read(1);
        issue_read(0);
        m1_bus.read = 1'b1;
        step();
        sd_bus.readdatavalid = 1'b1;
        sd_bus.readdata      = 64'h3000;
        neg();
        check("t5_pushpop_read", sd_bus.read, 1);
        check("t5_pushpop_m0_rdv", m0_bus.readdatavalid, 1);
        check("t5_pushpop_m1_rdv", m1_bus.readdatavalid, 0);
        step();
        m1_bus.read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sd_bus.readdata = 64'h3001 + 64'(i);
            neg();
            check("t5_order_m1", m1_bus.readdatavalid, (i != 1));
            check("t5_order_m0", m0_bus.readdatavalid, (i == 1));
            step();
        end
        sd_bus.readdatavalid = 1'b0;
        neg();
        check("t5_no_orphan", err_orphan, 0);
        step();

        // Reset with two reads outstanding; their beats become orphans
        issue_read(0);
        issue_read(1);
        reset = 1'b1;
        neg();
        check("t6_rst_m0_wait", m0_bus.waitrequest, 1);
        step();
        reset = 1'b0;
        sd_bus.readdatavalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sd_bus.readdata = 64'h4000 + 64'(i);
            neg();
            check("t6_no_m0_rdv", m0_bus.readdatavalid, 0);
            check("t6_no_m1_rdv", m1_bus.readdatavalid, 0);
            step();
        end
        sd_bus.readdatavalid = 1'b0;
        neg();
        check("t6_orphan_set", err_orphan, 1);
        step();
        step();
        neg();
        check("t6_orphan_sticky", err_orphan, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
